// File: rtl/ode_fmt_pkg.sv
// Shared definitions for the 16-bit scaled word {scale[2:0], mantissa[12:0]}.
// Used by the encoder, the add/sub datapath and the ODE stepper registers.
package ode_fmt_pkg;

  localparam int unsigned WORD_W  = 16;
  localparam int unsigned SCALE_W = 3;
  localparam int unsigned MANT_W  = 13;

  localparam logic [MANT_W-1:0] MANT_MAX = 13'h0FFF;
  localparam logic [MANT_W-1:0] MANT_MIN = 13'h1000;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StRound,
    StDone
  } enc_state_e;

  function automatic logic [WORD_W-1:0] pack_word(input logic [SCALE_W-1:0] scale,
                                                  input logic [MANT_W-1:0]  mant);
    return {scale, mant};
  endfunction

  function automatic logic [MANT_W-1:0] sat_mant(input logic neg);
    return neg ? MANT_MIN : MANT_MAX;
  endfunction

endpackage

// File: rtl/scaled_fit_check.sv
// Combinational fit test: the bits above the mantissa sign bit must all equal it.
// Callers pass acc[W-1:12] so the low mantissa bits stay with the caller.
module scaled_fit_check #(
  parameter int unsigned W = 24
) (
  input  logic [W-13:0] upper_i,
  output logic          fits_o
);

  assign fits_o = (&upper_i) | ~(|upper_i);

endmodule

// File: rtl/scaled_fp_encoder.sv
// Iterative fixed-point to scaled-word encoder, one arithmetic right shift per cycle.
// Define SCALED_ENC_ROUND_EN to round half-up on the last shifted-out bit.
module scaled_fp_encoder
  import ode_fmt_pkg::*;
#(
  parameter int unsigned IN_W    = 24,
  parameter int unsigned IN_FRAC = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_invalid,
  output logic              busy
);

  enc_state_e          state_q, state_d;
  logic [IN_W-1:0]     acc_q, acc_d;
  logic [SCALE_W-1:0]  scale_q, scale_d;
  logic [WORD_W-1:0]   out_data_q, out_data_d;
  logic                out_invalid_q, out_invalid_d;
  logic                acc_fits;

  scaled_fit_check #(
    .W (IN_W)
  ) u_fit_acc (
    .upper_i (acc_q[IN_W-1:12]),
    .fits_o  (acc_fits)
  );

`ifdef SCALED_ENC_ROUND_EN
  logic            guard_q, guard_d;
  logic [IN_W-1:0] sum;
  logic            sum_fits;

  assign sum = acc_q + IN_W'(guard_q);

  scaled_fit_check #(
    .W (IN_W)
  ) u_fit_sum (
    .upper_i (sum[IN_W-1:12]),
    .fits_o  (sum_fits)
  );
`endif

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    scale_d       = scale_q;
    out_data_d    = out_data_q;
    out_invalid_d = out_invalid_q;
`ifdef SCALED_ENC_ROUND_EN
    guard_d       = guard_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          acc_d   = in_data;
          scale_d = SCALE_W'(IN_FRAC);
`ifdef SCALED_ENC_ROUND_EN
          guard_d = 1'b0;
`endif
          state_d = StShift;
        end
      end
      StShift: begin
        if (acc_fits) begin
`ifdef SCALED_ENC_ROUND_EN
          state_d       = StRound;
`else
          out_data_d    = pack_word(scale_q, acc_q[MANT_W-1:0]);
          out_invalid_d = 1'b0;
          state_d       = StDone;
`endif
        end else if (scale_q != '0) begin
          acc_d   = {acc_q[IN_W-1], acc_q[IN_W-1:1]};
          scale_d = scale_q - 1'b1;
`ifdef SCALED_ENC_ROUND_EN
          guard_d = acc_q[0];
`endif
        end else begin
          out_data_d    = pack_word('0, sat_mant(acc_q[IN_W-1]));
          out_invalid_d = 1'b1;
          state_d       = StDone;
        end
      end
`ifdef SCALED_ENC_ROUND_EN
      StRound: begin
        // Rounding can only overflow at +4095; shift once more and recheck fit
        if (sum_fits) begin
          out_data_d    = pack_word(scale_q, sum[MANT_W-1:0]);
          out_invalid_d = 1'b0;
          state_d       = StDone;
        end else if (scale_q != '0) begin
          acc_d   = {sum[IN_W-1], sum[IN_W-1:1]};
          scale_d = scale_q - 1'b1;
          guard_d = sum[0];
          state_d = StShift;
        end else begin
          out_data_d    = pack_word('0, sat_mant(sum[IN_W-1]));
          out_invalid_d = 1'b1;
          state_d       = StDone;
        end
      end
`endif
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      acc_q         <= '0;
      scale_q       <= '0;
      out_data_q    <= '0;
      out_invalid_q <= 1'b0;
`ifdef SCALED_ENC_ROUND_EN
      guard_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      scale_q       <= scale_d;
      out_data_q    <= out_data_d;
      out_invalid_q <= out_invalid_d;
`ifdef SCALED_ENC_ROUND_EN
      guard_q       <= guard_d;
`endif
    end
  end

  assign in_ready    = (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign out_valid   = (state_q == StDone);
  assign out_data    = out_data_q;
  assign out_invalid = out_invalid_q;

endmodule

// File: doc/scaled_fp_encoder.md
Name: scaled_fp_encoder

Overview:
- Converts a wide two's-complement fixed-point value into the team's 16-bit scaled word: bits [15:13] are the scale s (number of fractional bits, 0..7), bits [12:0] are the signed mantissa. Value = mantissa × 2^-s.
- The encoder is the producer side of this format. It feeds the scaled-word add/sub datapath and the ODE stepper registers.
- It normalises iteratively, one right-shift per cycle, behind valid/ready handshakes.

Parameters:
- IN_W, 24: width of in_data. Must be ≥ 14.
- IN_FRAC, 7: fractional bits of in_data. Must be ≤ 7; the starting scale equals IN_FRAC.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_data valid
- in_ready  output  1  encoder can accept; high only in IDLE
- in_data  input  IN_W  signed fixed-point, IN_FRAC fractional bits
- out_valid  output  1  out_data/out_invalid valid
- out_ready  input  1  consumer accepts
- out_data  output  16  {scale[2:0], mantissa[12:0]}
- out_invalid  output  1  saturation occurred; held with out_data
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, immediate) values:
  - state = IDLE, in_ready = 1, out_valid = 0, out_data = 0, out_invalid = 0, busy = 0.
  - Internal accumulator and scale are cleared.
- Fit test: acc fits if acc[IN_W-1:12] are all equal (all 0 or all 1).
- IDLE:
  - On in_valid && in_ready, load acc = in_data and s = IN_FRAC, then go to SHIFT.
- SHIFT, evaluated every cycle:
  - If acc fits: go to DONE with mantissa = acc[12:0] and invalid = 0.
  - Else if s > 0: acc = acc >>> 1 (arithmetic) and s = s - 1. Stay in SHIFT.
  - Else (s = 0 and no fit): saturate. Mantissa = 13'h0FFF if acc ≥ 0, else 13'h1000; s = 0; invalid = 1. Go to DONE.
- DONE:
  - out_valid = 1. out_data and out_invalid are registered and stable while out_valid && !out_ready.
  - On out_ready: out_valid drops next cycle, return to IDLE, in_ready = 1.
- Latency:
  - In-fit case: accept at cycle 0, out_valid at cycle 2.
  - Each required shift adds 1 cycle. Worst case is IN_FRAC + 2 cycles.
- Throughput: one conversion in flight. in_ready stays low from accept until the output handshake completes; there is no skid buffer.
- Zero input gives out_data = {3'd7, 13'd0} when IN_FRAC = 7.
- in_valid asserted while busy is ignored. Its data is not captured.
- rst asserted mid-SHIFT or mid-DONE aborts the conversion. No out_valid is produced for that conversion.

Optional Feature:
- Macro: SCALED_ENC_ROUND_EN.
- With the macro defined:
  - Each shift records the shifted-out bit as the guard bit.
  - On reaching fit, the encoder enters ROUND for one cycle and adds guard to the mantissa (round-half-up).
  - If the add makes acc not fit and s > 0, it shifts once more (s-1) and rechecks.
  - If s = 0, it saturates and sets invalid = 1.
  - Conversions that need no shift still pass through ROUND, so latency is +1.
- Without the macro: truncation by arithmetic shift, and the ROUND state is absent.

Decomposition:
- Shared package ode_fmt_pkg:
  - Constants: WORD_W = 16, SCALE_W = 3, MANT_W = 13, MANT_MAX = 13'h0FFF, MANT_MIN = 13'h1000.
  - State encoding: IDLE, SHIFT, ROUND, DONE.
- One sub-module, scaled_fit_check: combinational test of acc[IN_W-1:12] for all-equal, outputting fits. It is reused by the add/sub post-checker.

Test Plan:
- in_data = 100, out_ready = 1 → out_valid at cycle 2, out_data = {3'd7, 13'd100}, out_invalid = 0.
- in_data = 5000 → 1 shift, out_data = {3'd6, 13'd2500}. With ROUND_EN, 5001 → {3'd6, 13'd2501}; without ROUND_EN, 5001 → 2500.
- in_data = -4096 → {3'd7, 13'h1000} with no shift. in_data = -5001 → {3'd6, -2501}; with ROUND_EN → -2500.
- in_data = 24'h7FFFFF → 7 shifts then saturate: {3'd0, 13'h0FFF}, out_invalid = 1. in_data = 24'h800000 → {3'd0, 13'h1000}, out_invalid = 1.
- Backpressure: out_ready held 0 for 5 cycles after out_valid → out_data stable, in_ready = 0, a second in_valid is ignored. On release, exactly one transfer, then in_ready = 1.
- rst pulsed during SHIFT of 24'h7FFFFF → all outputs at reset values immediately. A following conversion of 100 is correct.
